// File: rtl/prio_encoder_rr_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority request encoder.
package prio_encoder_rr_pkg;

   // Arbitration policy, sampled together with each accepted request vector.
   typedef enum logic {
      ENC_FIXED = 1'b0,   // highest set index wins
      ENC_RR    = 1'b1    // first set index after the last winner wins
   } enc_mode_e;

   // Index width for n inputs, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request / result handshake bundle between request sources, the encoder and its consumer.
interface prio_encoder_rr_if import prio_encoder_rr_pkg::*; #(
   parameter int N = 8,
   parameter int W = clog2_min1(N)
);
   logic [N-1:0] req;
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic [W-1:0] idx;
   logic         none;
   logic         out_valid;
   logic         out_ready;

   // Environment side: offers requests and consumes results.
   modport master (
      output req, in_valid, mode, out_ready,
      input  in_ready, idx, none, out_valid
   );

   // Encoder side.
   modport slave (
      input  req, in_valid, mode, out_ready,
      output in_ready, idx, none, out_valid
   );
endinterface

// File: rtl/prio_encoder_rr_prio_search.sv
// Combinational circular find-first-set: scans req upward from start, wrapping at N-1.
module prio_search import prio_encoder_rr_pkg::*; #(
   parameter  int N = 8,
   localparam int W = clog2_min1(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W:0]   sum_s;
   logic [W-1:0] pos_s;

   // Visit positions start, start+1, ... modulo N; the first set bit is the winner.
   always_comb begin
      found = 1'b0;
      idx   = {W{1'b0}};
      sum_s = {(W+1){1'b0}};
      pos_s = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         sum_s = {1'b0, start} + (W+1)'(i);
         // Wrap without a divider; start < N keeps sum below 2N.
         pos_s = W'((sum_s >= (W+1)'(N)) ? (sum_s - (W+1)'(N)) : sum_s);
         idx   = (req[pos_s] && !found) ? pos_s : idx;
         found = found | req[pos_s];
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-input request encoder with fixed or round-robin priority and a single-entry
// registered result behind valid/ready handshakes.
module prio_encoder_rr import prio_encoder_rr_pkg::*; #(
   parameter  int N = 8,
   localparam int W = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   prio_encoder_rr_if.slave bus
);

   logic [W-1:0] idx_r;
   logic         none_r;
   logic         out_valid_r;
   logic [W-1:0] rr_ptr_r;

   enc_mode_e    mode_s;
   logic [N-1:0] rev_req_s;
   logic [N-1:0] search_req_s;
   logic [W-1:0] rr_start_s;
   logic [W-1:0] start_s;
   logic         found_s;
   logic [W-1:0] hit_s;
   logic [W-1:0] win_idx_s;
   logic         in_ready_s;
   logic         accept_s;

   assign mode_s = enc_mode_e'(bus.mode);

   // Bit-reversed copy: an upward scan from 0 over it visits the highest real index first.
   for (genvar g = 0; g < N; g++) begin : g_rev
      assign rev_req_s[g] = bus.req[N-1-g];
   end

   // Round-robin search begins just past the previous winner, wrapping N-1 -> 0.
   always_comb begin
      if (rr_ptr_r == W'(N-1)) begin
         rr_start_s = {W{1'b0}};
      end else begin
         rr_start_s = rr_ptr_r + W'(1);
      end
   end

   // Steer the shared search: fixed mode scans the reversed vector from 0 and maps back.
   always_comb begin
      search_req_s = rev_req_s;
      start_s      = {W{1'b0}};
      win_idx_s    = W'(N-1) - hit_s;
      case (mode_s)
         ENC_FIXED: begin
            search_req_s = rev_req_s;
            start_s      = {W{1'b0}};
            win_idx_s    = W'(N-1) - hit_s;
         end
         ENC_RR: begin
            search_req_s = bus.req;
            start_s      = rr_start_s;
            win_idx_s    = hit_s;
         end
         default: begin
            search_req_s = rev_req_s;
            start_s      = {W{1'b0}};
            win_idx_s    = W'(N-1) - hit_s;
         end
      endcase
   end

   prio_search #(.N(N)) u_search (
      .req   (search_req_s),
      .start (start_s),
      .found (found_s),
      .idx   (hit_s)
   );

   // Single-entry output stage: free when empty or being drained this cycle.
   assign in_ready_s = ~out_valid_r | bus.out_ready;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Result register: load on accept, clear valid on a bare transfer, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r       <= {W{1'b0}};
         none_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         idx_r       <= found_s ? win_idx_s : {W{1'b0}};
         none_r      <= ~found_s;
         out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Round-robin pointer remembers the last RR winner; zero or fixed-mode accepts leave it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= W'(N-1);
      end else if (accept_s && (mode_s == ENC_RR) && found_s) begin
         rr_ptr_r <= win_idx_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.idx       = idx_r;
   assign bus.none      = none_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr: an N=8 and an N=5 instance run in lockstep
// against a behavioural model of the arbitration and handshake rules.
module tb_prio_encoder_rr;
   import prio_encoder_rr_pkg::*;

   logic clk;
   logic rst_n;

   prio_encoder_rr_if #(.N(8)) b8 ();
   prio_encoder_rr_if #(.N(5)) b5 ();

   prio_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   prio_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state per instance: [0] is N=8, [1] is N=5.
   bit m_valid [2];
   int m_idx   [2];
   bit m_none  [2];
   int m_ptr   [2];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Winner per the arbitration rules: fixed = highest set bit, RR = first set after ptr.
   function automatic void ref_pick(input logic [7:0] r, input int n, input bit rr,
                                    input int ptr, output bit f, output int ix);
      f  = 1'b0;
      ix = 0;
      if (!rr) begin
         for (int b = n - 1; b >= 0; b--) begin
            if (r[b]) begin f = 1'b1; ix = b; break; end
         end
      end else begin
         for (int k = 1; k <= n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (r[c]) begin f = 1'b1; ix = c; break; end
         end
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_idx[k]   = 0;
         m_none[k]  = 1'b0;
      end
      m_ptr[0] = 7;
      m_ptr[1] = 4;
   endtask

   task automatic drive(input logic [7:0] r8, input logic [4:0] r5, input bit iv,
                        input bit md, input bit ordy);
      b8.req = r8; b8.in_valid = iv; b8.mode = md; b8.out_ready = ordy;
      b5.req = r5; b5.in_valid = iv; b5.mode = md; b5.out_ready = ordy;
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic cycle();
      logic [7:0] r [2];
      bit md [2];
      bit iv [2];
      bit ordy [2];
      bit acc [2];
      bit f;
      int ix;
      int n;
      #1;
      r[0] = b8.req;       r[1] = {3'b000, b5.req};
      md[0] = b8.mode;     md[1] = b5.mode;
      iv[0] = b8.in_valid; iv[1] = b5.in_valid;
      ordy[0] = b8.out_ready; ordy[1] = b5.out_ready;
      chk("in_ready8", int'(b8.in_ready), int'(!m_valid[0] || ordy[0]));
      chk("in_ready5", int'(b5.in_ready), int'(!m_valid[1] || ordy[1]));
      for (int k = 0; k < 2; k++) acc[k] = iv[k] && (!m_valid[k] || ordy[k]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 8 : 5;
         if (acc[k]) begin
            ref_pick(r[k], n, md[k], m_ptr[k], f, ix);
            m_valid[k] = 1'b1;
            m_idx[k]   = f ? ix : 0;
            m_none[k]  = !f;
            if (md[k] && f) m_ptr[k] = ix;
         end else if (ordy[k]) begin
            m_valid[k] = 1'b0;
         end
      end
      chk("idx8",   int'(b8.idx),       m_idx[0]);
      chk("none8",  int'(b8.none),      int'(m_none[0]));
      chk("valid8", int'(b8.out_valid), int'(m_valid[0]));
      chk("idx5",   int'(b5.idx),       m_idx[1]);
      chk("none5",  int'(b5.none),      int'(m_none[1]));
      chk("valid5", int'(b5.out_valid), int'(m_valid[1]));
   endtask

   initial begin
      logic [7:0] v8;
      logic [4:0] v5;
      int exp8 [4];
      int exp5 [4];

      // Reset state.
      rst_n = 1'b0;
      drive(8'h00, 5'h00, 1'b0, 1'b0, 1'b1);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid8", int'(b8.out_valid), 0);
      chk("rst_idx8",   int'(b8.idx),       0);
      chk("rst_none8",  int'(b8.none),      0);
      chk("rst_rdy8",   int'(b8.in_ready),  1);
      chk("rst_valid5", int'(b5.out_valid), 0);
      rst_n = 1'b1;

      // One-hot sweep, fixed mode: plain encoder values, one cycle latency.
      for (int k = 0; k < 8; k++) begin
         v8 = 8'h01 << k;
         v5 = 5'h01 << (k % 5);
         drive(v8, v5, 1'b1, 1'b0, 1'b1);
         cycle();
         chk("sweep_idx8",  int'(b8.idx),  k);
         chk("sweep_none8", int'(b8.none), 0);
         chk("sweep_idx5",  int'(b5.idx),  k % 5);
      end

      // Multi-hot fixed: highest bit wins every time.
      for (int k = 0; k < 3; k++) begin
         drive(8'b1010_0110, 5'b10000, 1'b1, 1'b0, 1'b1);
         cycle();
         chk("fixed_multi8", int'(b8.idx), 7);
         chk("fixed_top5",   int'(b5.idx), 4);
      end

      // Round-robin from the reset pointer; fixed accepts above must not have moved it.
      exp8[0] = 1; exp8[1] = 4; exp8[2] = 7; exp8[3] = 1;
      exp5[0] = 0; exp5[1] = 4; exp5[2] = 0; exp5[3] = 4;
      for (int k = 0; k < 4; k++) begin
         drive(8'b1001_0010, 5'b10001, 1'b1, 1'b1, 1'b1);
         cycle();
         chk("rr_idx8", int'(b8.idx), exp8[k]);
         chk("rr_idx5", int'(b5.idx), exp5[k]);
      end

      // Zero request still produces a result, flagged with none.
      drive(8'h00, 5'h00, 1'b1, 1'b0, 1'b1);
      cycle();
      chk("zero_none8", int'(b8.none), 1);
      chk("zero_idx8",  int'(b8.idx),  0);
      chk("zero_none5", int'(b5.none), 1);

      // Backpressure: result held, new requests refused.
      for (int k = 0; k < 5; k++) begin
         drive(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b0);
         cycle();
         chk("bp_ready8", int'(b8.in_ready),  0);
         chk("bp_valid8", int'(b8.out_valid), 1);
         chk("bp_none8",  int'(b8.none),      1);
      end

      // Release: the pending request is accepted in the same cycle as the transfer.
      drive(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b1);
      #1;
      chk("rel_ready8", int'(b8.in_ready), 1);
      cycle();
      chk("rel_idx8",   int'(b8.idx),       7);
      chk("rel_valid8", int'(b8.out_valid), 1);
      chk("rel_idx5",   int'(b5.idx),       4);

      // Randomised traffic against the model.
      for (int k = 0; k < 400; k++) begin
         v8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         v5 = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
         drive(v8, v5, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0);
         cycle();
      end

      // Drain, then move the RR pointer away from its reset value.
      drive(8'h00, 5'h00, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(8'h08, 5'h02, 1'b1, 1'b1, 1'b1);
      cycle();
      chk("pre_rst_idx8", int'(b8.idx), 3);

      // Stall with a pending result, then reset asynchronously mid-cycle.
      drive(8'h01, 5'h01, 1'b1, 1'b1, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid8", int'(b8.out_valid), 0);
      chk("midrst_valid5", int'(b5.out_valid), 0);
      chk("midrst_idx8",   int'(b8.idx),       0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Pointer back at N-1: an all-ones RR request picks index 0.
      drive(8'hFF, 5'h1F, 1'b1, 1'b1, 1'b1);
      cycle();
      chk("post_rst_idx8", int'(b8.idx), 0);
      chk("post_rst_idx5", int'(b5.idx), 0);

      drive(8'h00, 5'h00, 1'b0, 1'b0, 1'b1);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
